// File: rtl/right_shifter_pkg.sv
// Shared types and helpers for the multi-channel right shifter.
// Holds the controller state encoding and width/shift utilities.
package right_shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam int MAXW = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Right shift of the low w bits of v by k, filling vacated bits
  function automatic logic [MAXW-1:0] shr_fill(
    input logic [MAXW-1:0] v,
    input int              w,
    input int              k,
    input logic            fill
  );
    logic [MAXW-1:0] m;
    logic [MAXW-1:0] r;
    m = (64'd1 << w) - 64'd1;
    r = (v & m) >> k;
    if (fill) r = r | (m & ~(m >> k));
    return r;
  endfunction

endpackage

// File: rtl/rs_lane.sv
// One data lane: shift register, guard bit and rounding adder.
// Driven in lockstep by the shared controller strobes.
module rs_lane
  import right_shifter_pkg::*;
#(
  parameter int BW = 15,
  parameter int KW = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          load,
  input  logic          shift,
  input  logic          fin,
  input  logic          arith,
  input  logic          round,
  input  logic [KW-1:0] k,
  input  logic [BW-1:0] din,
  output logic [BW-1:0] dout
);

  logic [BW-1:0]   sr_q;
  logic            g_q;
  logic [BW-1:0]   out_q;
  logic [MAXW-1:0] shv;
  logic [MAXW-1:0] gv;
  logic            fill;

  assign fill = arith & sr_q[BW-1];
  assign shv  = shr_fill(MAXW'(sr_q), BW, int'(k), fill);
  assign gv   = MAXW'(sr_q) >> (int'(k) - 1);
  assign dout = out_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sr_q  <= '0;
      g_q   <= 1'b0;
      out_q <= '0;
    end else begin
      if (load) begin
        sr_q <= din;
        g_q  <= 1'b0;
      end else if (shift) begin
        sr_q <= shv[BW-1:0];
        g_q  <= gv[0];
      end
      if (fin) out_q <= sr_q + BW'(g_q & round);
    end
  end

endmodule

// File: rtl/right_shifter_mc.sv
// Multi-channel iterative right shifter with Start/Busy/Done handshake.
// Controller, remaining counter and amount clamp around CH lanes.
module right_shifter_mc
  import right_shifter_pkg::*;
#(
  parameter int BW    = 15,
  parameter int CH    = 2,
  parameter int STEP  = 1,
  parameter int AMT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Arith,
  input  logic             Round,
  input  logic [AMT_W-1:0] Amount,
  input  logic [CH*BW-1:0] In,
  output logic [CH*BW-1:0] Out,
  output logic             Busy,
  output logic             Done
);

  localparam int RW = clog2(BW + 1);

  state_t        state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [RW-1:0] amt_c;
  logic [RW-1:0] k;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          arith_q, round_q;
  logic          load, shift, fin;

  assign amt_c = (32'(Amount) > BW) ? RW'(BW) : RW'(Amount);
  assign k     = (32'(rem_q) > STEP) ? RW'(STEP) : rem_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          rem_d   = amt_c;
          state_d = (amt_c != '0) ? SHIFT : FINAL;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        rem_d = rem_q - k;
        if (rem_q == k) state_d = FINAL;
      end
      FINAL: begin
        fin     = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      arith_q <= 1'b0;
      round_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (load) begin
        arith_q <= Arith;
        round_q <= Round;
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    rs_lane #(
      .BW(BW),
      .KW(RW)
    ) u_lane (
      .Clock(Clock),
      .Reset(Reset),
      .load (load),
      .shift(shift),
      .fin  (fin),
      .arith(arith_q),
      .round(round_q),
      .k    (k),
      .din  (In[c*BW +: BW]),
      .dout (Out[c*BW +: BW])
    );
  end

endmodule

// File: doc/right_shifter_mc.md
# right_shifter_mc

Multi-channel iterative right shifter, the parametrised successor to the two-channel logical shifter used in the FFT scaling path of the stereo spectrum analyzer. It right-shifts CH channels of BW bits by a common runtime amount. Selectable modes: logical or arithmetic shift, and optional round-half-up. It shifts STEP bits per clock and signals completion with a Start/Busy/Done handshake. It sits between the butterfly/accumulator stages and the magnitude/display logic, and applies block-exponent scaling.

## Interface
- BW, 15: data width per channel.
- CH, 2: number of channels.
- STEP, 1: maximum bits shifted per clock (1..BW).
- AMT_W, 5: width of Amount.
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request; accepted only in IDLE.
- Arith  in  1  1 = arithmetic shift (sign-fill); 0 = logical (zero-fill). Latched on accept.
- Round  in  1  1 = add the last shifted-out bit to the result (round half up). Latched on accept.
- Amount  in  AMT_W  shift count. Latched on accept. Values above BW are clamped to BW.
- In  in  CH*BW  channel c occupies bits [c*BW +: BW].
- Out  out  CH*BW  result. Held until the next completion.
- Busy  out  1  high from the edge that accepts Start until the completion edge.
- Done  out  1  one-cycle pulse, coincident with the Out update.

## Operation
- Reset values: Out=0, Busy=0, Done=0, state IDLE, all internal registers 0.
- FSM states:
  - IDLE: on Start, latch In, Arith, Round and clamped Amount; clear the per-channel guard bits; set Busy. Go to SHIFT if Amount≠0, else FINAL.
  - SHIFT: each cycle shift by k=min(STEP, remaining). Fill is the channel MSB if Arith, else 0. Guard bit ← the bit at position k-1 before the shift (the last bit shifted out). Decrement remaining by k. When remaining reaches 0, go to FINAL.
  - FINAL: Out ← shift register + (Round ? guard : 0), per channel, modulo 2^BW. Done=1, Busy=0. Go to IDLE.
- Start is ignored in SHIFT and FINAL (Busy=1). It has no effect on any latched value.
- Rounding cannot overflow. For Amount=0 the guard is 0. A positive value shifted ≥1 place is at most 2^(BW-2)-1. An arithmetic full shift of a negative value gives -1 with guard 1, which rounds to 0. No saturation logic is needed.
- Amount clamped to BW: logical mode gives 0 (round: MSB of input). Arithmetic mode gives all-sign (round: 0 for negative, 0 for positive).
- All channels share Amount and mode, and run in lockstep.
- Done is cleared on the cycle after FINAL.

## Timing
- N = ceil(min(Amount,BW)/STEP) shift cycles.
- Start sampled at edge 0. Busy=1 after edge 0.
- The shift occupies edges 1..N. FINAL occurs at edge N+1: Out updates, Done=1 and Busy=0 after that edge. Done falls after edge N+2.
- Latency from Start to Done is N+1 cycles. Amount=0 gives 1 cycle.
- The earliest next Start is accepted at edge N+2, so back-to-back issue costs N+2 cycles per operation.
- Reset asserted mid-operation: Out, Busy and Done clear immediately (asynchronously). The FSM returns to IDLE. The first Start after release is accepted normally.

## Structure
- Package right_shifter_pkg holds:
  - the FSM state enum (IDLE, SHIFT, FINAL);
  - a clog2 constant function used for the remaining-counter width (clog2(BW+1));
  - a local shift-by-k helper.
- Sub-module rs_lane is instantiated CH times via generate. Each lane has its shift register, guard bit and rounding adder, and takes k, Arith, load and finalize strobes from the shared controller.
- Top level: controller FSM, remaining counter, Amount clamp, lane array.

## Test plan
- Default params, Arith=0, Round=0, Amount=4, In ch0=0x1234, ch1=0x7FFF -> Out ch0=0x0123, ch1=0x07FF. Done pulses exactly 5 cycles after the Start edge. Busy high for 5 cycles.
- Arith=1, Round=1, Amount=3, ch0=0x4000 (−16384), ch1=0x000B -> ch0=0x7800 (−2048), ch1=0x0001 (11>>3=1, guard=0). Repeat with Amount=2 -> ch1=0x0003.
- Amount=0 -> Out=In, Done 1 cycle after Start. Amount=20 with Arith=1, ch0=0x4000 -> 0x7FFF. Same with Round=1 -> 0x0000. Same with Arith=0 -> 0x0000.
- Instance STEP=4, Amount=9, ch0=0x7FFF, Arith=0 -> 3 shift cycles, Done at cycle 4, Out ch0=0x003F.
- Start re-asserted while Busy, with different Amount and In -> ignored. The result matches the first request, and the next Start at edge N+2 is accepted.
- Reset driven low during SHIFT -> Out=0, Busy=0, Done=0 without a clock edge. Release, then Start with Amount=1, ch0=0x0002 -> Out ch0=0x0001 after 2 cycles.
